// File: rtl/bsg_channel_widen_pkg.sv
// Shared defaults and width helpers for the narrow-to-wide channel reassembly stage.
package bsg_channel_widen_pkg;

  localparam int width_in_default  = 8;
  localparam int width_out_default = 16;

  function automatic int els_of(input int width_in, input int width_out);
    return (width_in > 0) ? width_out / width_in : 0;
  endfunction

  // A word must split into a whole number of beats, at least two of them.
  function automatic bit ratio_ok(input int width_in, input int width_out);
    return (width_in > 0) && (width_out % width_in == 0) && (width_out / width_in >= 2);
  endfunction

endpackage

// File: rtl/bsg_channel_widen_dff_reset_en.sv
// Enabled register with asynchronous active-high clear; holds the completed word and its valid flag.
module bsg_channel_widen_dff_reset_en #(
  parameter int width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)   data_r <= '0;
    else if (en_i) data_r <= data_i;
  end

  assign data_o = data_r;

endmodule

// File: rtl/bsg_channel_widen.sv
// Reassembles width_in_p-bit beats into width_out_p-bit words, beat 0 in the low slice.
// Accumulator collects all but the last beat; the last beat loads the output register directly.
module bsg_channel_widen
  import bsg_channel_widen_pkg::*;
#(
  parameter int width_in_p  = width_in_default,
  parameter int width_out_p = width_out_default
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   v_i,
  input  logic [width_in_p-1:0]  data_i,
  output logic                   ready_o,
  output logic                   v_o,
  output logic [width_out_p-1:0] data_o,
  input  logic                   yumi_i
);

  localparam int els_lp    = els_of(width_in_p, width_out_p);
  localparam int lg_els_lp = (els_lp > 1) ? $clog2(els_lp) : 1;
  localparam logic [lg_els_lp-1:0] last_lp = lg_els_lp'(els_lp - 1);

  if (!ratio_ok(width_in_p, width_out_p)) begin : g_bad_ratio
    $error("bsg_channel_widen: width_out_p must be a multiple (>=2x) of width_in_p");
  end

  logic [lg_els_lp-1:0]                 count_r;
  logic [els_lp-2:0][width_in_p-1:0]    acc_r;
  logic                                 full_r;
  logic                                 last;
  logic                                 accept;
  logic                                 complete;

  assign last     = (count_r == last_lp);
  // Only the completing beat needs the output register, so only it can stall.
  assign ready_o  = ~last | ~full_r | yumi_i;
  assign accept   = v_i & ready_o;
  assign complete = accept & last;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_r <= '0;
      acc_r   <= '0;
    end else if (accept) begin
      if (last) begin
        count_r <= '0;
      end else begin
        count_r <= count_r + 1'b1;
        for (int i = 0; i < els_lp - 1; i++)
          if (count_r == lg_els_lp'(i)) acc_r[i] <= data_i;
      end
    end
  end

  bsg_channel_widen_dff_reset_en #(.width_p(width_out_p)) word_reg (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (complete),
    .data_i  ({data_i, acc_r}),
    .data_o  (data_o)
  );

  // A completing beat keeps the flag set even when the old word is taken the same cycle.
  bsg_channel_widen_dff_reset_en #(.width_p(1)) full_reg (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (complete | yumi_i),
    .data_i  (complete),
    .data_o  (full_r)
  );

  assign v_o = full_r;

endmodule

// File: tb/tb_bsg_channel_widen.sv
// Directed bench for bsg_channel_widen: vector table plus streaming, 32-bit and async-reset sequences.
module tb_bsg_channel_widen;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        v_i, yumi_i, ready_o, v_o;
  logic [7:0]  data_i;
  logic [15:0] data_o;
  logic        v32_i, yumi32_i, ready32_o, v32_o;
  logic [7:0]  data32_i;
  logic [31:0] data32_o;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bsg_channel_widen #(.width_in_p(8), .width_out_p(16)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i)
  );

  bsg_channel_widen #(.width_in_p(8), .width_out_p(32)) dut32 (
    .clk_i(clk), .reset_i(reset_i), .v_i(v32_i), .data_i(data32_i), .ready_o(ready32_o),
    .v_o(v32_o), .data_o(data32_o), .yumi_i(yumi32_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        yumi;
    logic        exp_ready;
    logic        exp_v;
    logic [15:0] exp_data;
  } vec_t;

  vec_t tbl[14];

  function automatic logic [7:0] sbeat(input int i);
    return 8'(8'hA0 + i);
  endfunction

  initial begin
    int nw;
    // outputs are observed in the same cycle the inputs are presented
    tbl[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[2]  = '{1'b1, 8'h34, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[3]  = '{1'b1, 8'h12, 1'b0, 1'b1, 1'b0, 16'h0000};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 16'h1234};
    tbl[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h1234};
    tbl[6]  = '{1'b1, 8'hEF, 1'b0, 1'b1, 1'b0, 16'h1234};
    tbl[7]  = '{1'b1, 8'hBE, 1'b0, 1'b1, 1'b0, 16'h1234};
    tbl[8]  = '{1'b1, 8'hAD, 1'b0, 1'b1, 1'b1, 16'hBEEF};
    tbl[9]  = '{1'b1, 8'hDE, 1'b0, 1'b0, 1'b1, 16'hBEEF};
    tbl[10] = '{1'b1, 8'hDE, 1'b0, 1'b0, 1'b1, 16'hBEEF};
    tbl[11] = '{1'b1, 8'hDE, 1'b1, 1'b1, 1'b1, 16'hBEEF};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 16'hDEAD};
    tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'hDEAD};

    reset_i = 1'b1;
    v_i = 1'b0; data_i = '0; yumi_i = 1'b0;
    v32_i = 1'b0; data32_i = '0; yumi32_i = 1'b0;
    #1;
    check("reset_v", 32'(v_o), 32'd0);
    check("reset_data", 32'(data_o), 32'd0);
    check("reset_ready", 32'(ready_o), 32'd1);
    @(negedge clk);
    reset_i = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      v_i = tbl[i].v; data_i = tbl[i].d; yumi_i = tbl[i].yumi;
      #1;
      check($sformatf("vec%0d_ready", i), 32'(ready_o), 32'(tbl[i].exp_ready));
      check($sformatf("vec%0d_v", i), 32'(v_o), 32'(tbl[i].exp_v));
      check($sformatf("vec%0d_data", i), 32'(data_o), 32'(tbl[i].exp_data));
    end

    // streaming: a beat every cycle, consumer takes each word as it appears
    nw = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      v_i = (i < 16); data_i = (i < 16) ? sbeat(i) : 8'h00;
      yumi_i = v_o;
      #1;
      if (i < 16) check($sformatf("stream%0d_ready", i), 32'(ready_o), 32'd1);
      if (v_o) begin
        check($sformatf("stream_word%0d", nw), 32'(data_o), 32'({sbeat(2*nw+1), sbeat(2*nw)}));
        nw++;
      end
    end
    check("stream_word_count", 32'(nw), 32'd8);
    @(negedge clk);
    v_i = 1'b0; yumi_i = 1'b0;
    #1 check("stream_drained_v", 32'(v_o), 32'd0);

    // 4:1 ratio
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      v32_i = 1'b1; data32_i = 8'(i + 1);
      #1 check($sformatf("w32_beat%0d_ready", i), 32'(ready32_o), 32'd1);
      check($sformatf("w32_beat%0d_v", i), 32'(v32_o), 32'd0);
    end
    @(negedge clk);
    v32_i = 1'b0; yumi32_i = 1'b1;
    #1 check("w32_v", 32'(v32_o), 32'd1);
    check("w32_data", data32_o, 32'h04030201);
    @(negedge clk);
    yumi32_i = 1'b0;
    #1 check("w32_after_v", 32'(v32_o), 32'd0);

    // async reset with a pending word and a partial beat in flight
    @(negedge clk); v_i = 1'b1; data_i = 8'h77;
    @(negedge clk); v_i = 1'b1; data_i = 8'h66;
    @(negedge clk); v_i = 1'b1; data_i = 8'h55;
    #1 check("pre_reset_v", 32'(v_o), 32'd1);
    check("pre_reset_data", 32'(data_o), 32'h6677);
    @(negedge clk); v_i = 1'b0;
    #2 reset_i = 1'b1;
    #1 check("async_reset_v", 32'(v_o), 32'd0);
    check("async_reset_data", 32'(data_o), 32'd0);
    check("async_reset_ready", 32'(ready_o), 32'd1);
    @(negedge clk); reset_i = 1'b0;
    @(negedge clk); v_i = 1'b1; data_i = 8'h11;
    #1 check("post_reset_v", 32'(v_o), 32'd0);
    check("post_reset_ready", 32'(ready_o), 32'd1);
    @(negedge clk); v_i = 1'b1; data_i = 8'h22;
    #1 check("post_reset_partial_v", 32'(v_o), 32'd0);
    @(negedge clk); v_i = 1'b0; yumi_i = 1'b1;
    #1 check("post_reset_word_v", 32'(v_o), 32'd1);
    check("post_reset_word", 32'(data_o), 32'h2211);
    @(negedge clk); yumi_i = 1'b0;
    #1 check("post_reset_drained_v", 32'(v_o), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // consumer must never take a word that is not there
  always @(negedge clk) begin
    #2;
    if (yumi_i && !reset_i) check("yumi_legal", 32'(v_o), 32'd1);
    if (yumi32_i && !reset_i) check("yumi32_legal", 32'(v32_o), 32'd1);
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
